// File: rtl/bram_out_demux_pkg.sv
// Shared constants and tag type for the BRAM read-return path.
package bram_out_demux_pkg;

  localparam int NUM_PORTS = 20;
  localparam int SEL_W     = 5;
  localparam int DATA_W    = 32;

  // Read tag carried alongside the BRAM latency: a valid bit and the destination slot.
  typedef struct packed {
    logic             v;
    logic [SEL_W-1:0] dest;
  } tag_t;

  // True when the destination index names an existing slot.
  function automatic logic dest_ok(input logic [SEL_W-1:0] d);
    return int'(d) < NUM_PORTS;
  endfunction

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// RD_LAT-deep shift register that delays a read tag so it lines up with BRAM data.
module bram_rd_tag_pipe
  import bram_out_demux_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_reg [RD_LAT];

  // First stage captures the tag of the read issued this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg[0] <= '0;
    end else begin
      stage_reg[0] <= tag_in;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_stage
      // Each later stage shifts the tag one cycle closer to the data return.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_reg[gi] <= '0;
        end else begin
          stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign tag_out = stage_reg[RD_LAT-1];

endmodule

// File: rtl/bram_out_demux.sv
// Steers returned BRAM words into per-destination one-entry holding registers.
module bram_out_demux
  import bram_out_demux_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_issue,
  input  logic [SEL_W-1:0]            rd_dest,
  input  logic [DATA_W-1:0]           bram_dout,
  input  logic [NUM_PORTS-1:0]        ack,
  input  logic                        err_clr,
  output logic [NUM_PORTS*DATA_W-1:0] dout,
  output logic [NUM_PORTS-1:0]        dout_valid,
  output logic                        err_overflow,
  output logic                        err_bad_dest
);

  tag_t                 issue_tag;
  tag_t                 ret_tag;
  logic                 bad_now;
  logic [NUM_PORTS-1:0] ovf_hit;
  logic [NUM_PORTS-1:0] valid_reg;
  logic [DATA_W-1:0]    data_reg [NUM_PORTS];
  logic                 err_overflow_reg;
  logic                 err_bad_dest_reg;

  // Illegal destinations become bubbles so nothing is written for them.
  always_comb begin
    issue_tag      = '0;
    issue_tag.v    = rd_issue && dest_ok(rd_dest);
    issue_tag.dest = rd_dest;
    bad_now        = rd_issue && !dest_ok(rd_dest);
  end

  bram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (issue_tag),
    .tag_out (ret_tag)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
      logic wr;
      assign wr = ret_tag.v && (ret_tag.dest == SEL_W'(gi));
      // An unacked slot being overwritten loses its old word.
      assign ovf_hit[gi] = wr && valid_reg[gi] && !ack[gi];

      // Return write takes priority over ack; ack alone frees the slot but keeps the word.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (wr) begin
          data_reg[gi]  <= bram_dout;
          valid_reg[gi] <= 1'b1;
        end else if (ack[gi]) begin
          valid_reg[gi] <= 1'b0;
        end
      end

      assign dout[gi*DATA_W +: DATA_W] = data_reg[gi];
    end
  endgenerate

  // Sticky error flags: a new error beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow_reg <= 1'b0;
      err_bad_dest_reg <= 1'b0;
    end else begin
      err_overflow_reg <= (|ovf_hit) || (err_overflow_reg && !err_clr);
      err_bad_dest_reg <= bad_now || (err_bad_dest_reg && !err_clr);
    end
  end

  assign dout_valid   = valid_reg;
  assign err_overflow = err_overflow_reg;
  assign err_bad_dest = err_bad_dest_reg;

endmodule
